io_bus_mouse_fifo: RTL and testbench

- Memory-mapped mouse peripheral for the 8-bit CPU bus.
- Each complete packet from the mouse transceiver (status, X, Y, Z) is pushed into a parametrised packet FIFO, so the CPU can fall behind by up to FIFO depth packets without losing any.
- Adds a control register, a sticky overflow flag, an explicit pop register and a maskable interrupt that is re-armed while the FIFO is non-empty.

---
 rtl/io_bus_mouse_fifo_pkg.sv | 24 ++
 rtl/io_bus_mouse_fifo_if.sv | 21 ++
 rtl/io_bus_mouse_fifo_pkt_fifo.sv | 43 ++++
 rtl/io_bus_mouse_fifo.sv | 78 +++++++
 tb/tb_io_bus_mouse_fifo.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/io_bus_mouse_fifo_pkg.sv
// mouse_io_pkg: register map, control/status bit positions and packet layout
// shared by the bus mouse FIFO peripheral.
package mouse_io_pkg;
    localparam int PKT_W = 28;
    localparam int REG_STATUS = 0;
    localparam int REG_X = 1;
    localparam int REG_Y = 2;
    localparam int REG_Z = 3;
    localparam int REG_STAT = 4;
    localparam int REG_CTRL = 5;
    localparam int REG_POP = 6;
    localparam int IRQ_EN_BIT = 0;
    localparam int FLUSH_BIT = 1;
    localparam int OVF_CLR_BIT = 2;
    localparam int STAT_FULL_BIT = 5;
    localparam int STAT_EMPTY_BIT = 6;
    localparam int STAT_OVF_BIT = 7;
    typedef struct packed {
        logic [3:0] status;
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] z;
    } pkt_t;
endpackage

// File: rtl/io_bus_mouse_fifo_if.sv
// io_bus_mouse_fifo_if: CPU address/strobe, transceiver packet strobe and the
// interrupt request/acknowledge pair; the tristate data bus stays a plain port.
interface io_bus_mouse_fifo_if;
    logic [7:0] BUS_ADDR;
    logic       BUS_WE;
    logic       BUS_INTERRUPT_RAISE;
    logic       BUS_INTERRUPT_ACK;
    logic       PKT_VALID;
    logic [3:0] PKT_STATUS;
    logic [7:0] PKT_X;
    logic [7:0] PKT_Y;
    logic [7:0] PKT_Z;
    modport master (
        output BUS_ADDR, BUS_WE, BUS_INTERRUPT_ACK, PKT_VALID, PKT_STATUS, PKT_X, PKT_Y, PKT_Z,
        input  BUS_INTERRUPT_RAISE
    );
    modport slave (
        input  BUS_ADDR, BUS_WE, BUS_INTERRUPT_ACK, PKT_VALID, PKT_STATUS, PKT_X, PKT_Y, PKT_Z,
        output BUS_INTERRUPT_RAISE
    );
endinterface

// File: rtl/io_bus_mouse_fifo_pkt_fifo.sv
// mouse_pkt_fifo: synchronous packet FIFO with flush; full/empty come from the
// occupancy count so a full FIFO can still accept a push alongside a pop.
module mouse_pkt_fifo
    import mouse_io_pkg::*;
#(
    parameter int AW = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  pkt_t        din,
    output pkt_t        head,
    output logic        full,
    output logic        empty,
    output logic        push_ok,
    output logic        pop_ok,
    output logic [AW:0] count
);
    localparam int DEPTH = 2**AW;
    pkt_t mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    always_comb begin
        empty = count == '0;
        full = count == (AW+1)'(DEPTH);
        pop_ok = pop && !empty && !flush;
        push_ok = push && !flush && (!full || pop_ok);
        head = mem[rd_ptr];
    end
    always_ff @(posedge CLK) begin
        if (RESET || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
    always_ff @(posedge CLK) if (push_ok) mem[wr_ptr] <= din;
endmodule

// File: rtl/io_bus_mouse_fifo.sv
// io_bus_mouse_fifo: memory-mapped mouse peripheral that queues transceiver
// packets, with control, sticky overflow, explicit pop and maskable interrupt.
module io_bus_mouse_fifo
    import mouse_io_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = 8'hA0,
    parameter int         ADDR_WIDTH = 3,
    parameter int         FIFO_AW    = 2,
    parameter logic       IRQ_EN_RST = 1'b1
) (
    input  logic               CLK,
    input  logic               RESET,
    inout  wire  [7:0]         BUS_DATA,
    io_bus_mouse_fifo_if.slave bus
);
    logic cs, rd, wr, ctrl_wr, pop_wr, flush, ovf_clr, ovf_evt, irq_set;
    logic [ADDR_WIDTH-1:0] off;
    logic full, empty, push_ok, pop_ok;
    logic [FIFO_AW:0] count;
    pkt_t head, hd, pkt;
    logic ovf, irq, irq_en, drv;
    logic [7:0] dout, rdata, stat;

    mouse_pkt_fifo #(.AW(FIFO_AW)) u_fifo (
        .CLK(CLK), .RESET(RESET), .push(bus.PKT_VALID), .pop(pop_wr), .flush(flush),
        .din(pkt), .head(head), .full(full), .empty(empty),
        .push_ok(push_ok), .pop_ok(pop_ok), .count(count)
    );

    always_comb begin
        cs = {1'b0, bus.BUS_ADDR} >= {1'b0, BASE_ADDR}
          && {1'b0, bus.BUS_ADDR} < {1'b0, BASE_ADDR} + 9'(2**ADDR_WIDTH);
        off = bus.BUS_ADDR[ADDR_WIDTH-1:0];
        rd = cs && !bus.BUS_WE;
        wr = cs && bus.BUS_WE;
        ctrl_wr = wr && off == ADDR_WIDTH'(REG_CTRL);
        pop_wr = wr && off == ADDR_WIDTH'(REG_POP);
        flush = ctrl_wr && BUS_DATA[FLUSH_BIT];
        ovf_clr = ctrl_wr && BUS_DATA[OVF_CLR_BIT];
        // a packet flushed away in the same cycle is discarded, not an overflow
        ovf_evt = bus.PKT_VALID && !push_ok && !flush;
        irq_set = irq_en && (push_ok || (pop_ok && count > (FIFO_AW+1)'(1)));
        pkt = {bus.PKT_STATUS, bus.PKT_X, bus.PKT_Y, bus.PKT_Z};
        hd = empty ? '0 : head;
        stat = '0;
        stat[STAT_OVF_BIT] = ovf;
        stat[STAT_EMPTY_BIT] = empty;
        stat[STAT_FULL_BIT] = full;
        stat[FIFO_AW:0] = count;
        rdata = off == ADDR_WIDTH'(REG_STATUS) ? {4'h0, hd.status}
              : off == ADDR_WIDTH'(REG_X) ? hd.x
              : off == ADDR_WIDTH'(REG_Y) ? hd.y
              : off == ADDR_WIDTH'(REG_Z) ? hd.z
              : off == ADDR_WIDTH'(REG_STAT) ? stat
              : off == ADDR_WIDTH'(REG_CTRL) ? {7'h0, irq_en}
              : 8'h00;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ovf <= 1'b0;
            irq <= 1'b0;
            irq_en <= IRQ_EN_RST;
            drv <= 1'b0;
            dout <= 8'h00;
        end else begin
            drv <= rd;
            if (rd) dout <= rdata;
            ovf <= ovf_evt || (ovf && !ovf_clr);
            irq_en <= ctrl_wr ? BUS_DATA[IRQ_EN_BIT] : irq_en;
            irq <= (ctrl_wr && !BUS_DATA[IRQ_EN_BIT]) ? 1'b0
                 : irq_set || (irq && !bus.BUS_INTERRUPT_ACK);
        end
    end

    assign BUS_DATA = drv ? dout : 8'hzz;
    assign bus.BUS_INTERRUPT_RAISE = irq;
endmodule

// File: tb/tb_io_bus_mouse_fifo.sv
// tb_io_bus_mouse_fifo: directed plan plus randomized traffic, checked every
// cycle against a queue-based model of the register/FIFO rules.
module tb_io_bus_mouse_fifo;
    localparam logic [7:0] BASE = 8'hA0;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tb_drv = 1'b0;
    logic [7:0] tb_dout = 8'h00;
    wire [7:0] bus_data;
    int n_pass = 0;
    int n_tot = 0;
    bit chk_on = 1'b0;

    io_bus_mouse_fifo_if bus();
    io_bus_mouse_fifo #(.BASE_ADDR(BASE), .ADDR_WIDTH(3), .FIFO_AW(2), .IRQ_EN_RST(1'b1)) dut (
        .CLK(clk), .RESET(rst), .BUS_DATA(bus_data), .bus(bus)
    );

    assign bus_data = tb_drv ? tb_dout : 8'hzz;
    pullup (bus_data);
    always #5 clk = ~clk;

    // behavioural model: a packet queue plus the flag registers
    logic [27:0] q[$];
    logic m_ovf, m_irq, m_en, m_drv;
    logic [7:0] m_dout;

    function automatic logic [7:0] reg_val(logic [2:0] o);
        logic [27:0] h;
        h = q.size() > 0 ? q[0] : 28'h0;
        case (o)
            3'd0: return {4'h0, h[27:24]};
            3'd1: return h[23:16];
            3'd2: return h[15:8];
            3'd3: return h[7:0];
            3'd4: return {m_ovf, q.size() == 0, q.size() == DEPTH, 5'(q.size())};
            3'd5: return {7'h0, m_en};
            default: return 8'h00;
        endcase
    endfunction

    always @(posedge clk) begin
        logic [2:0] o;
        logic cs, rd, wr, cw, pw, fl, popped, acc;
        if (rst) begin
            q.delete();
            m_ovf = 1'b0;
            m_irq = 1'b0;
            m_en = 1'b1;
            m_drv = 1'b0;
            m_dout = 8'h00;
            chk_on = 1'b1;
        end else begin
            cs = bus.BUS_ADDR inside {[8'hA0:8'hA7]};
            o = bus.BUS_ADDR[2:0];
            rd = cs && !bus.BUS_WE;
            wr = cs && bus.BUS_WE;
            cw = wr && o == 3'd5;
            pw = wr && o == 3'd6;
            m_drv = rd;
            if (rd) m_dout = reg_val(o);
            fl = cw && tb_dout[1];
            popped = 1'b0;
            acc = 1'b0;
            if (fl) q.delete();
            else begin
                popped = pw && q.size() > 0;
                acc = bus.PKT_VALID && (q.size() < DEPTH || popped);
                if (popped) void'(q.pop_front());
                if (acc) q.push_back({bus.PKT_STATUS, bus.PKT_X, bus.PKT_Y, bus.PKT_Z});
            end
            if (bus.PKT_VALID && !acc && !fl) m_ovf = 1'b1;
            else if (cw && tb_dout[2]) m_ovf = 1'b0;
            if (cw && !tb_dout[0]) m_irq = 1'b0;
            else if (m_en && (acc || (popped && q.size() >= 1))) m_irq = 1'b1;
            else if (bus.BUS_INTERRUPT_ACK) m_irq = 1'b0;
            if (cw) m_en = tb_dout[0];
        end
    end

    task automatic check(string n, logic [7:0] g, logic [7:0] e);
        n_tot++;
        if (g !== e) $display("FAIL %s: got %h expected %h at %0t", n, g, e, $time);
        else n_pass++;
    endtask

    always @(negedge clk) if (chk_on) begin
        check("irq", {7'h0, bus.BUS_INTERRUPT_RAISE}, {7'h0, m_irq});
        check("bus_data", bus_data, m_drv ? m_dout : (tb_drv ? tb_dout : 8'hFF));
    end

    task automatic idle();
        bus.BUS_ADDR = 8'h00;
        bus.BUS_WE = 1'b0;
        bus.BUS_INTERRUPT_ACK = 1'b0;
        bus.PKT_VALID = 1'b0;
        tb_drv = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        idle();
    endtask

    // read, check in the following cycle, then leave one idle cycle so the
    // DUT has released the bus before any write
    task automatic rd(logic [7:0] a, logic [7:0] e, string n);
        bus.BUS_ADDR = a;
        step();
        @(negedge clk);
        check(n, bus_data, e);
        @(posedge clk);
        #1;
    endtask

    task automatic wr(logic [2:0] o, logic [7:0] d);
        bus.BUS_ADDR = BASE + 8'(o);
        bus.BUS_WE = 1'b1;
        tb_drv = 1'b1;
        tb_dout = d;
        step();
    endtask

    task automatic pkt(logic [27:0] p);
        bus.PKT_VALID = 1'b1;
        {bus.PKT_STATUS, bus.PKT_X, bus.PKT_Y, bus.PKT_Z} = p;
        step();
    endtask

    task automatic irq_is(logic e, string n);
        @(negedge clk);
        check(n, {7'h0, bus.BUS_INTERRUPT_RAISE}, {7'h0, e});
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit last_rd;
        int op;
        idle();
        {bus.PKT_STATUS, bus.PKT_X, bus.PKT_Y, bus.PKT_Z} = 28'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd(BASE + 8'd4, 8'h40, "stat_reset");
        rd(BASE + 8'd0, 8'h00, "status_empty");
        irq_is(1'b0, "irq_reset");

        pkt(28'h905FB01);
        irq_is(1'b1, "irq_push");
        rd(BASE + 8'd0, 8'h09, "head_status");
        rd(BASE + 8'd1, 8'h05, "head_x");
        rd(BASE + 8'd2, 8'hFB, "head_y");
        rd(BASE + 8'd3, 8'h01, "head_z");
        bus.BUS_INTERRUPT_ACK = 1'b1;
        step();
        irq_is(1'b0, "irq_ack");
        wr(3'd6, 8'h00);
        rd(BASE + 8'd4, 8'h40, "stat_popped");
        irq_is(1'b0, "irq_pop_to_empty");

        for (int i = 1; i <= 5; i++) pkt({4'(i), 8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i)});
        rd(BASE + 8'd4, 8'hA4, "stat_overflow");
        rd(BASE + 8'd1, 8'h11, "head_pkt1");
        wr(3'd5, 8'h05);
        rd(BASE + 8'd4, 8'h24, "stat_ovf_clr");

        bus.PKT_VALID = 1'b1;
        {bus.PKT_STATUS, bus.PKT_X, bus.PKT_Y, bus.PKT_Z} = 28'hCAABBCC;
        wr(3'd6, 8'h00);
        rd(BASE + 8'd4, 8'h24, "stat_full_push_pop");
        for (int i = 0; i < 3; i++) wr(3'd6, 8'h00);
        rd(BASE + 8'd1, 8'hAA, "head_new_pkt");

        wr(3'd6, 8'h00);
        pkt(28'h1111111);
        pkt(28'h2222222);
        bus.BUS_INTERRUPT_ACK = 1'b1;
        step();
        irq_is(1'b0, "irq_acked_two");
        wr(3'd6, 8'h00);
        irq_is(1'b1, "irq_rearm");
        wr(3'd5, 8'h00);
        irq_is(1'b0, "irq_en_off");
        pkt(28'h3333333);
        irq_is(1'b0, "irq_masked");
        rd(BASE + 8'd4, 8'h02, "stat_two");

        bus.PKT_VALID = 1'b1;
        wr(3'd5, 8'h02);
        rd(BASE + 8'd4, 8'h40, "stat_flush");
        rd(8'hA8, 8'hFF, "z_A8");
        rd(8'h9F, 8'hFF, "z_9F");

        bus.BUS_ADDR = BASE + 8'd4;
        rst = 1'b1;
        step();
        @(negedge clk);
        check("rst_during_read", bus_data, 8'hFF);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rd(BASE + 8'd5, 8'h01, "ctrl_reset");

        last_rd = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            idle();
            op = int'($urandom_range(0, 9));
            rst = $urandom_range(0, 499) == 0;
            bus.PKT_VALID = $urandom_range(0, 2) == 0;
            bus.PKT_STATUS = 4'($urandom);
            bus.PKT_X = 8'($urandom);
            bus.PKT_Y = 8'($urandom);
            bus.PKT_Z = 8'($urandom);
            bus.BUS_INTERRUPT_ACK = $urandom_range(0, 5) == 0;
            if (op <= 2) begin
                bus.BUS_ADDR = op == 0 ? 8'($urandom) : 8'(BASE + $urandom_range(0, 7));
            end else if (!last_rd) begin
                bus.BUS_WE = 1'b1;
                tb_drv = 1'b1;
                tb_dout = 8'($urandom);
                bus.BUS_ADDR = op <= 5 ? BASE + 8'd6 : op <= 7 ? BASE + 8'd5
                             : op == 8 ? 8'(BASE + $urandom_range(0, 7)) : 8'($urandom);
                if (bus.BUS_ADDR == BASE + 8'd5)
                    tb_dout = {5'h0, $urandom_range(0, 7) == 0, 1'($urandom), $urandom_range(0, 5) != 0};
            end
            last_rd = op <= 2;
            @(posedge clk);
            #1;
        end
        idle();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
